// File: rtl/depacketizer_arb_pkg.sv
// Shared types and helpers for the depacketizer round-robin arbiter.
// Optional burst locking is enabled with DEPACKETIZER_ARB_BURST_LOCK_EN.
package depacketizer_arb_pkg;

  localparam int DEFAULT_VC_ADDRESS_WIDTH = 1;
  localparam int DEFAULT_BURST_MAX        = 4;

  typedef logic [DEFAULT_VC_ADDRESS_WIDTH-1:0] vc_idx_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Counter must hold the value BURST_MAX itself, hence the extra bit.
  localparam int BURST_CNT_WIDTH = clog2(DEFAULT_BURST_MAX) + 1;

  function automatic int wrap_idx(input int base, input int offset, input int num);
    int sum;
    sum = base + offset;
    return (sum >= num) ? (sum - num) : sum;
  endfunction

endpackage

// File: rtl/depacketizer_arbiter_rr_priority_select.sv
// Combinational round-robin selector: rotate requests by ptr, pick the
// lowest set bit, then rotate the index back into absolute VC numbering.
module rr_priority_select
  import depacketizer_arb_pkg::*;
#(
  parameter int NUM_VC           = 2,
  parameter int VC_ADDRESS_WIDTH = 1
) (
  input  logic [NUM_VC-1:0]           req,
  input  logic [VC_ADDRESS_WIDTH-1:0] ptr,
  output logic [VC_ADDRESS_WIDTH-1:0] gnt_idx,
  output logic                        gnt_valid
);

  logic [NUM_VC-1:0]           rot;
  logic [VC_ADDRESS_WIDTH-1:0] offset;

  always_comb begin
    rot = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      rot[k] = req[wrap_idx(int'(ptr), k, NUM_VC)];
    end
  end

  // Descending scan so the lowest rotated position wins.
  always_comb begin
    offset = '0;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = VC_ADDRESS_WIDTH'(k);
      end
    end
  end

  assign gnt_valid = |rot;
  assign gnt_idx   = VC_ADDRESS_WIDTH'(wrap_idx(int'(ptr), int'(offset), NUM_VC));

endmodule

// File: rtl/depacketizer_arbiter.sv
// Round-robin arbiter feeding one shared depacketizer through a one-entry
// registered stage. Define DEPACKETIZER_ARB_BURST_LOCK_EN for burst locking.
module depacketizer_arbiter
  import depacketizer_arb_pkg::*;
#(
  parameter int NUM_VC           = 2,
  parameter int VC_ADDRESS_WIDTH = DEFAULT_VC_ADDRESS_WIDTH,
  parameter int WIDTH_PKT        = 36,
  parameter int BURST_MAX        = DEFAULT_BURST_MAX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_VC*WIDTH_PKT-1:0]   data_in,
  input  logic [NUM_VC-1:0]             valid_in,
  output logic [NUM_VC-1:0]             ready_out,
  output logic [WIDTH_PKT-1:0]          data_out,
  output logic [VC_ADDRESS_WIDTH-1:0]   vc_out,
  output logic                          valid_out,
  input  logic                          ready_in
);

  logic [VC_ADDRESS_WIDTH-1:0] ptr;
  logic [VC_ADDRESS_WIDTH-1:0] rr_idx;
  logic                        rr_valid;
  logic [VC_ADDRESS_WIDTH-1:0] gnt_idx;
  logic                        gnt_valid;
  logic [VC_ADDRESS_WIDTH-1:0] next_ptr;
  logic [WIDTH_PKT-1:0]        sel_data;
  logic                        slot_free;
  logic                        take;

  rr_priority_select #(
    .NUM_VC           (NUM_VC),
    .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH)
  ) u_select (
    .req       (valid_in),
    .ptr       (ptr),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

`ifdef DEPACKETIZER_ARB_BURST_LOCK_EN
  localparam int CNT_W = clog2(BURST_MAX) + 1;

  logic [VC_ADDRESS_WIDTH-1:0] lst;
  logic [CNT_W-1:0]            cnt;
  logic                        lock_hold;

  assign lock_hold = valid_in[lst] && (cnt < CNT_W'(BURST_MAX));
  assign gnt_idx   = lock_hold ? lst : rr_idx;
  assign gnt_valid = lock_hold || rr_valid;

  // Count saturates at BURST_MAX so a lone requester cannot wrap back into a lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lst <= '0;
      cnt <= '0;
    end else if (take) begin
      if (gnt_idx == lst) begin
        if (cnt != CNT_W'(BURST_MAX)) begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        lst <= gnt_idx;
        cnt <= CNT_W'(1);
      end
    end
  end
`else
  assign gnt_idx   = rr_idx;
  assign gnt_valid = rr_valid;
`endif

  assign slot_free = !valid_out || ready_in;
  assign take      = slot_free && gnt_valid;
  assign next_ptr  = VC_ADDRESS_WIDTH'(wrap_idx(int'(gnt_idx), 1, NUM_VC));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (gnt_idx == VC_ADDRESS_WIDTH'(i)) begin
        sel_data = data_in[i*WIDTH_PKT +: WIDTH_PKT];
      end
    end
  end

  always_comb begin
    ready_out = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      ready_out[i] = take && (gnt_idx == VC_ADDRESS_WIDTH'(i)) && !rst;
    end
  end

  // ptr always lands one past the last winner, which is also where round-robin
  // resumes once a burst lock releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      vc_out    <= '0;
      ptr       <= '0;
    end else if (take) begin
      valid_out <= 1'b1;
      data_out  <= sel_data;
      vc_out    <= gnt_idx;
      ptr       <= next_ptr;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_depacketizer_arbiter.sv
// Self-checking bench for depacketizer_arbiter: directed table, corner
// sequences and random traffic against a spec-level model with a scoreboard.
module tb_depacketizer_arbiter;

  localparam int NV = 4;
  localparam int AW = 2;
  localparam int PW = 36;
  localparam int BM = 3;

  typedef struct {
    logic [NV-1:0] valid;
    logic          ready;
    logic [NV-1:0] exp_ready;
    logic          exp_valid;
    int            exp_vc;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NV*PW-1:0]     data_in;
  logic [NV-1:0]        valid_in;
  logic [NV-1:0]        ready_out;
  logic [PW-1:0]        data_out;
  logic [AW-1:0]        vc_out;
  logic                 valid_out;
  logic                 ready_in;

  int total = 0;
  int bad   = 0;

  int            m_ptr, m_lst, m_cnt, m_vc;
  logic          m_valid;
  logic [PW-1:0] m_data;
  logic [AW+PW-1:0] sb[$];

  vec_t vecs[12];

  always #5 clk = ~clk;

  depacketizer_arbiter #(
    .NUM_VC           (NV),
    .VC_ADDRESS_WIDTH (AW),
    .WIDTH_PKT        (PW),
    .BURST_MAX        (BM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .vc_out    (vc_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_lst = 0; m_cnt = 0; m_vc = 0;
    m_valid = 1'b0;
    m_data = '0;
    sb.delete();
  endfunction

  // First valid source searching from the pointer, unless a burst lock holds.
  function automatic void model_grant(input logic [NV-1:0] v, output bit ok, output int idx);
    ok = 1'b0;
    idx = 0;
`ifdef DEPACKETIZER_ARB_BURST_LOCK_EN
    if (v[m_lst] && m_cnt < BM) begin
      ok = 1'b1;
      idx = m_lst;
      return;
    end
`endif
    for (int k = 0; k < NV; k++) begin
      if (!ok && v[(m_ptr + k) % NV]) begin
        ok = 1'b1;
        idx = (m_ptr + k) % NV;
      end
    end
  endfunction

  function automatic logic [NV*PW-1:0] row_data(input int tag);
    logic [NV*PW-1:0] r;
    for (int vc = 0; vc < NV; vc++) r[vc*PW +: PW] = {4'(vc), 32'(tag)};
    return r;
  endfunction

  function automatic logic [NV*PW-1:0] rand_data();
    logic [NV*PW-1:0] r;
    for (int vc = 0; vc < NV; vc++) r[vc*PW +: PW] = {4'($urandom), 32'($urandom)};
    return r;
  endfunction

  // Drive one cycle from a negedge, check before the rising edge, update model after it.
  task automatic applyStimulus(input logic [NV-1:0] v, input logic r, input logic [NV*PW-1:0] d,
                               output logic [NV-1:0] obs_ready);
    bit ok;
    int idx;
    bit take;
    logic [NV-1:0] exp_r;
    logic [AW+PW-1:0] front;
    valid_in = v;
    ready_in = r;
    data_in  = d;
    #1;
    obs_ready = ready_out;
    model_grant(v, ok, idx);
    take  = (!m_valid || r) && ok;
    exp_r = take ? (NV'(1) << idx) : '0;
    checkOutput("ready_out", ready_out, exp_r);
    checkOutput("valid_out", valid_out, m_valid);
    checkOutput("data_out", data_out, m_data);
    checkOutput("vc_out", vc_out, m_vc);
    if (m_valid && r) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_underflow: got packet %0h, expected none", data_out);
      end else begin
        front = sb.pop_front();
        checkOutput("sb_order", {vc_out, data_out}, front);
      end
    end
    @(posedge clk);
    if (take) begin
      m_data  = d[idx*PW +: PW];
      m_vc    = idx;
      m_valid = 1'b1;
      m_ptr   = (idx + 1) % NV;
      sb.push_back({AW'(idx), d[idx*PW +: PW]});
`ifdef DEPACKETIZER_ARB_BURST_LOCK_EN
      if (idx == m_lst) begin
        if (m_cnt < BM) m_cnt = m_cnt + 1;
      end else begin
        m_lst = idx;
        m_cnt = 1;
      end
`endif
    end else if (r) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic pulseReset(input logic [NV-1:0] v);
    rst = 1'b1;
    valid_in = v;
    ready_in = 1'b1;
    #1;
    checkOutput("rst_ready_out", ready_out, 0);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_vc_out", vc_out, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NV-1:0] obs;
    logic [PW-1:0] tbl_data;
    int cnt0, cnt1, acc;

`ifdef DEPACKETIZER_ARB_BURST_LOCK_EN
    vecs[0]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    vecs[1]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    vecs[2]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    vecs[3]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    vecs[4]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    vecs[5]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    vecs[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    vecs[7]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    vecs[8]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1};
    vecs[9]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 1};
    vecs[10] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    vecs[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 3};
`else
    vecs[0]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    vecs[1]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    vecs[2]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 1};
    vecs[3]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    vecs[4]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1};
    vecs[5]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 3};
    vecs[6]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1};
    vecs[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2};
    vecs[10] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2};
    vecs[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 0};
`endif

    rst = 1'b1;
    valid_in = '0;
    ready_in = 1'b0;
    data_in = '0;
    model_reset();
    @(negedge clk);
    pulseReset('0);

    // Directed table from a fresh reset.
    tbl_data = '0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].ready, row_data(100 + i), obs);
      if (vecs[i].exp_ready != '0) tbl_data = {4'(vecs[i].exp_vc), 32'(100 + i)};
      checkOutput("tbl_ready", obs, vecs[i].exp_ready);
      checkOutput("tbl_valid", valid_out, vecs[i].exp_valid);
      checkOutput("tbl_vc", vc_out, vecs[i].exp_vc);
      checkOutput("tbl_data", data_out, tbl_data);
    end

    // Reset while a packet sits in the output register.
    pulseReset('0);
    applyStimulus(4'b0001, 1'b0, {{(NV-1)*PW{1'b0}}, 36'hA5}, obs);
    checkOutput("hold_a5_valid", valid_out, 1);
    checkOutput("hold_a5_data", data_out, 36'hA5);
    pulseReset(4'b0011);
    applyStimulus(4'b0011, 1'b1, row_data(7), obs);
    checkOutput("post_rst_grant", obs, 4'b0001);

    // Fairness with two permanently valid sources.
    pulseReset('0);
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(4'b0011, 1'b1, row_data(200 + i), obs);
      if (valid_out && vc_out == 0) cnt0++;
      if (valid_out && vc_out == 1) cnt1++;
    end
`ifdef DEPACKETIZER_ARB_BURST_LOCK_EN
    checkOutput("fair_vc0", cnt0, 51);
    checkOutput("fair_vc1", cnt1, 49);
`else
    checkOutput("fair_vc0", cnt0, 50);
    checkOutput("fair_vc1", cnt1, 50);
`endif

    // Backpressure: five stalled cycles, then release.
    pulseReset('0);
    applyStimulus(4'b0011, 1'b1, row_data(300), obs);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011, 1'b0, row_data(301 + i), obs);
      checkOutput("stall_ready", obs, 4'b0000);
    end
    applyStimulus(4'b0011, 1'b1, row_data(310), obs);
    applyStimulus(4'b0000, 1'b1, row_data(311), obs);
    applyStimulus(4'b0000, 1'b1, row_data(312), obs);

    // Single source toggling valid every cycle.
    pulseReset('0);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1, row_data(400 + i), obs);
      acc += int'(obs[2]);
    end
    checkOutput("toggle_accepts", acc, 20);

    // Random traffic against the model and scoreboard.
    pulseReset('0);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(NV'($urandom), ($urandom_range(9, 0) < 7), rand_data(), obs);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, 1'b1, rand_data(), obs);
    end
    checkOutput("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
